// File: rtl/prio_level_stack.sv
// Priority-level stack: saves {level, return PC} on interrupt entry, restores on return,
// and strobes the ra write so the return marker lands in ra at the newly entered level.
module prio_level_stack #(
    parameter int          PRIO_W   = 3,
    parameter int          PC_W     = 32,
    parameter int          DEPTH    = (1 << PRIO_W) - 1,
    parameter logic [31:0] RA_MAGIC = 32'hFFFF_FFFF,
    localparam int         DW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take,
    input  logic [PRIO_W-1:0] take_prio,
    input  logic [PC_W-1:0]   take_pc,
    output logic              take_ack,
    input  logic              ret,
    output logic              ret_valid,
    output logic [PC_W-1:0]   ret_pc,
    output logic [PRIO_W-1:0] level,
    output logic              ra_we,
    output logic [31:0]       ra_data,
    output logic [DW-1:0]     depth,
    output logic              full,
    output logic              empty,
    output logic              err
);

    logic [PRIO_W-1:0] level_q, level_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [PC_W-1:0]   ret_pc_q, ret_pc_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ra_we_q, ra_we_d;
    logic              err_q, err_d;

    logic [PRIO_W-1:0] mem_lvl_q [DEPTH];
    logic [PC_W-1:0]   mem_pc_q  [DEPTH];
    logic [DW-1:0]     top_idx;

    assign full     = (depth_q == DW'(DEPTH));
    assign empty    = (depth_q == '0);
    assign top_idx  = depth_q - DW'(1);
    // A return in the same cycle always wins; the take is re-evaluated next cycle.
    assign take_ack = take & ~ret & ~full & (take_prio > level_q);

    always_comb begin
        level_d     = level_q;
        depth_d     = depth_q;
        ret_pc_d    = ret_pc_q;
        err_d       = err_q;
        ret_valid_d = 1'b0;
        ra_we_d     = 1'b0;
        if (ret) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                depth_d     = top_idx;
                level_d     = mem_lvl_q[top_idx];
                ret_pc_d    = mem_pc_q[top_idx];
                ret_valid_d = 1'b1;
            end
        end else if (take_ack) begin
            depth_d = depth_q + DW'(1);
            level_d = take_prio;
            ra_we_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q     <= '0;
            depth_q     <= '0;
            ret_pc_q    <= '0;
            ret_valid_q <= 1'b0;
            ra_we_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            level_q     <= level_d;
            depth_q     <= depth_d;
            ret_pc_q    <= ret_pc_d;
            ret_valid_q <= ret_valid_d;
            ra_we_q     <= ra_we_d;
            err_q       <= err_d;
        end
    end

    // Stack contents need no reset; only depth_q decides what is live.
    always_ff @(posedge clk) begin
        if (take_ack) begin
            mem_lvl_q[depth_q] <= level_q;
            mem_pc_q[depth_q]  <= take_pc;
        end
    end

    assign level     = level_q;
    assign depth     = depth_q;
    assign ret_pc    = ret_pc_q;
    assign ret_valid = ret_valid_q;
    assign ra_we     = ra_we_q;
    assign err       = err_q;
    assign ra_data   = RA_MAGIC;

endmodule

// File: tb/tb_prio_level_stack.sv
// Scoreboard bench for prio_level_stack: a queue-based stack model predicts acks, state
// and the one-cycle ret_valid / ra_we strobes; a monitor consumes the strobe predictions.
module tb_prio_level_stack;

    localparam int PRIO_W = 3;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 7;
    localparam int DW     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              take = 1'b0;
    logic [PRIO_W-1:0] take_prio = '0;
    logic [PC_W-1:0]   take_pc = '0;
    logic              ret = 1'b0;
    logic              take_ack, ret_valid, ra_we, full, empty, err;
    logic [PC_W-1:0]   ret_pc;
    logic [PRIO_W-1:0] level;
    logic [31:0]       ra_data;
    logic [DW-1:0]     depth;

    prio_level_stack #(.PRIO_W(PRIO_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .take(take), .take_prio(take_prio), .take_pc(take_pc),
        .take_ack(take_ack), .ret(ret), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .level(level), .ra_we(ra_we), .ra_data(ra_data), .depth(depth),
        .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { int due; bit is_ret; int lvl; logic [31:0] pc; } ev_t;
    typedef struct { int lvl; logic [31:0] pc; } fr_t;
    ev_t         sbq[$];
    fr_t         stk[$];
    int          m_lvl = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_last = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Strobe monitor: each predicted event must appear exactly on its due cycle.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                if (e.is_ret) begin
                    chk("ret_valid", 64'(ret_valid), 64'd1);
                    chk("ret_pc", 64'(ret_pc), 64'(e.pc));
                    chk("ret_level", 64'(level), 64'(e.lvl));
                    chk("ra_we_on_ret", 64'(ra_we), 64'd0);
                end else begin
                    chk("ra_we", 64'(ra_we), 64'd1);
                    chk("ra_data", 64'(ra_data), 64'h0000_0000_FFFF_FFFF);
                    chk("ra_level", 64'(level), 64'(e.lvl));
                    chk("ret_valid_on_take", 64'(ret_valid), 64'd0);
                end
            end else begin
                chk("no_strobe", 64'({ret_valid, ra_we}), 64'd0);
            end
        end
    end

    task automatic check_state();
        chk("level", 64'(level), 64'(m_lvl));
        chk("depth", 64'(depth), 64'(stk.size()));
        chk("empty", 64'(empty), 64'(stk.size() == 0));
        chk("full", 64'(full), 64'(stk.size() == DEPTH));
        chk("err", 64'(err), 64'(m_err));
        chk("ret_pc_held", 64'(ret_pc), 64'(m_last));
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic step(bit t, int p, logic [31:0] pc, bit r);
        bit exp_ack;
        fr_t f;
        take = t; take_prio = PRIO_W'(p); take_pc = pc; ret = r;
        @(negedge clk);
        exp_ack = t && !r && (stk.size() < DEPTH) && (p > m_lvl);
        chk("take_ack", 64'(take_ack), 64'(exp_ack));
        check_state();
        if (r) begin
            if (stk.size() == 0) begin
                m_err = 1'b1;
            end else begin
                f = stk.pop_back();
                m_lvl = f.lvl;
                m_last = f.pc;
                sbq.push_back('{cyc + 1, 1'b1, f.lvl, f.pc});
            end
        end else if (exp_ack) begin
            stk.push_back('{m_lvl, pc});
            m_lvl = p;
            sbq.push_back('{cyc + 1, 1'b0, p, 32'h0});
        end
        @(posedge clk);
        #1;
        take = 1'b0; ret = 1'b0;
    endtask

    task automatic do_reset_mid();
        #1 reset = 1'b1;
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_strobes", 64'({ret_valid, ra_we, err}), 64'd0);
        chk("rst_ret_pc", 64'(ret_pc), 64'd0);
        stk.delete(); sbq.delete();
        m_lvl = 0; m_err = 1'b0; m_last = '0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("init_level", 64'(level), 64'd0);
        chk("init_empty", 64'(empty), 64'd1);
        step(0, 0, 0, 0);

        step(1, 2, 32'h100, 0);
        chk("t2_level", 64'(level), 64'd2);
        chk("t2_ra_we", 64'(ra_we), 64'd1);
        step(1, 1, 32'h1, 0);
        chk("t2_ra_we_low", 64'(ra_we), 64'd0);
        step(1, 2, 32'h2, 0);
        step(1, 5, 32'h200, 0);
        chk("t3_depth", 64'(depth), 64'd2);
        step(0, 0, 0, 1);
        chk("t4_ret_pc1", 64'(ret_pc), 64'h200);
        step(0, 0, 0, 1);
        chk("t4_ret_pc2", 64'(ret_pc), 64'h100);
        step(0, 0, 0, 1);
        chk("t4_err", 64'(err), 64'd1);
        step(0, 0, 0, 0);

        do_reset_mid();
        for (int i = 1; i <= DEPTH; i++) step(1, i, 32'h1000 + 32'(i), 0);
        chk("t5_full", 64'(full), 64'd1);
        step(1, 7, 32'hDEAD, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        step(1, 1, 32'h11, 0);
        step(1, 3, 32'h33, 0);
        step(1, 4, 32'h44, 1);
        chk("t6_level_after_ret", 64'(level), 64'd1);
        step(1, 4, 32'h44, 0);
        chk("t6_level", 64'(level), 64'd4);
        step(1, 6, 32'h66, 0);
        do_reset_mid();
        step(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset_mid();
            end else begin
                step(bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
                     32'($urandom), bit'($urandom_range(0, 3) == 0));
            end
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
